pmod_kpd: RTL and testbench

- Scanner/decoder for a Digilent Pmod KYPD 4x4 hex keypad.
- Drives the four column lines one at a time, low, and samples the four active-low row lines.
- Reports the held key as a 4-bit hex code plus a level "pressed" flag.
- Feeds the keyboard decoder, which accepts digits 0-9 and commits a digit after release.

---
 rtl/pmod_kpd_pkg.sv | 34 +++
 rtl/pmod_kpd_if.sv | 24 ++
 rtl/pmod_kpd.sv | 115 +++++++++++
 tb/tb_pmod_kpd.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pmod_kpd_pkg.sv
// Shared constants for the Pmod KYPD scanner: keypad geometry, the "no key" code
// and the row/column to hex-code key map.
package pmod_kpd_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam logic [3:0] NO_KEY = 4'hF;

  // Key map; row 0 is J7 (top), column 0 is J1 (left).
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'h0;
      4'd13:   code = 4'hF;
      4'd14:   code = 4'hE;
      4'd15:   code = 4'hD;
      default: code = NO_KEY;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/pmod_kpd_if.sv
// Keypad-side lines of the Pmod KYPD plus the decoded key report.
// The scanner takes the slave view; the keypad/consumer side takes the master view.
interface pmod_kpd_if;
  logic       J1;
  logic       J2;
  logic       J3;
  logic       J4;
  logic       J7;
  logic       J8;
  logic       J9;
  logic       J10;
  logic [3:0] outnum;
  logic       pressed;

  modport slave (
    input  J7, J8, J9, J10,
    output J1, J2, J3, J4, outnum, pressed
  );

  modport master (
    output J7, J8, J9, J10,
    input  J1, J2, J3, J4, outnum, pressed
  );
endinterface

// File: rtl/pmod_kpd.sv
// 4x4 keypad scanner: walks the active-low column drives J1..J4, samples the rows at
// the end of each column's settle window and reports the first hit of each frame.
module pmod_kpd
  import pmod_kpd_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic       slow_clk,
  input  logic       rst,
  pmod_kpd_if.slave  kpd
);

  localparam int CW = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  logic [NUM_ROWS-1:0] row_s1_r;
  logic [NUM_ROWS-1:0] row_s2_r;
  logic [CW-1:0]       cnt_r;
  logic [1:0]          col_r;
  logic [NUM_COLS-1:0] col_drv_r;
  logic                hit_r;
  logic [3:0]          hit_code_r;
  logic                frame_end_r;
  logic                pressed_r;
  logic [3:0]          outnum_r;

  logic                last_s;
  logic [1:0]          col_nxt_s;
  logic                row_hit_s;
  logic [1:0]          row_idx_s;

  assign last_s    = (cnt_r == CNT_LAST);
  assign col_nxt_s = col_r + 2'd1;

  // Lowest closed row of the current column wins (J7 first).
  always_comb begin
    row_hit_s = 1'b0;
    row_idx_s = 2'd0;
    casez (row_s2_r)
      4'b???0: begin row_hit_s = 1'b1; row_idx_s = 2'd0; end
      4'b??01: begin row_hit_s = 1'b1; row_idx_s = 2'd1; end
      4'b?011: begin row_hit_s = 1'b1; row_idx_s = 2'd2; end
      4'b0111: begin row_hit_s = 1'b1; row_idx_s = 2'd3; end
      default: begin row_hit_s = 1'b0; row_idx_s = 2'd0; end
    endcase
  end

  // Two-flop row synchronizer; idle rows read high.
  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      row_s1_r <= 4'hF;
      row_s2_r <= 4'hF;
    end else begin
      row_s1_r <= {kpd.J10, kpd.J9, kpd.J8, kpd.J7};
      row_s2_r <= row_s1_r;
    end
  end

  // Settle counter and column walk; the drive is registered from the next index.
  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      cnt_r       <= '0;
      col_r       <= 2'd0;
      col_drv_r   <= 4'b1110;
      frame_end_r <= 1'b0;
    end else if (last_s) begin
      cnt_r       <= '0;
      col_r       <= col_nxt_s;
      col_drv_r   <= ~(4'b0001 << col_nxt_s);
      frame_end_r <= (col_r == 2'd3);
    end else begin
      cnt_r       <= cnt_r + CW'(1);
      frame_end_r <= 1'b0;
    end
  end

  // Frame accumulator: keep only the first hit, which is the earliest column scanned.
  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      hit_r      <= 1'b0;
      hit_code_r <= NO_KEY;
    end else if (frame_end_r) begin
      hit_r      <= 1'b0;
      hit_code_r <= hit_code_r;
    end else if (last_s && row_hit_s && !hit_r) begin
      hit_r      <= 1'b1;
      hit_code_r <= key_code(row_idx_s, col_r);
    end else begin
      hit_r      <= hit_r;
      hit_code_r <= hit_code_r;
    end
  end

  // Report update at the frame boundary; outnum holds through frames without a key.
  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      pressed_r <= 1'b0;
      outnum_r  <= NO_KEY;
    end else if (frame_end_r) begin
      pressed_r <= hit_r;
      outnum_r  <= hit_r ? hit_code_r : outnum_r;
    end else begin
      pressed_r <= pressed_r;
      outnum_r  <= outnum_r;
    end
  end

  assign kpd.J1      = col_drv_r[0];
  assign kpd.J2      = col_drv_r[1];
  assign kpd.J3      = col_drv_r[2];
  assign kpd.J4      = col_drv_r[3];
  assign kpd.pressed = pressed_r;
  assign kpd.outnum  = outnum_r;

endmodule

// File: tb/tb_pmod_kpd.sv
// Directed bench for pmod_kpd: a keypad model closes rows against the driven column,
// and expected codes/timings are hand-derived constants.
module tb_pmod_kpd;

  localparam int SETTLE = 4;
  localparam int FRAME  = 4 * SETTLE;
  localparam int BOUND  = 8 * SETTLE + 1;

  logic        slow_clk = 1'b0;
  logic        rst      = 1'b0;
  logic [15:0] keys     = 16'h0000;   // bit r*4+c: key at row r (J7..J10), column c (J1..J4)
  int          n_chk    = 0;
  int          n_pass   = 0;

  pmod_kpd_if kpd_bus ();

  pmod_kpd #(.SETTLE(SETTLE)) dut (
    .slow_clk (slow_clk),
    .rst      (rst),
    .kpd      (kpd_bus.slave)
  );

  always #5 slow_clk = ~slow_clk;

  logic [3:0] col_low;
  assign col_low = ~{kpd_bus.J4, kpd_bus.J3, kpd_bus.J2, kpd_bus.J1};
  assign kpd_bus.J7  = ~|(keys[3:0]   & col_low);
  assign kpd_bus.J8  = ~|(keys[7:4]   & col_low);
  assign kpd_bus.J9  = ~|(keys[11:8]  & col_low);
  assign kpd_bus.J10 = ~|(keys[15:12] & col_low);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_pressed(input logic lvl);
    int n;
    n = 0;
    while (kpd_bus.pressed !== lvl && n < BOUND) begin
      @(negedge slow_clk);
      n++;
    end
  endtask

  function automatic logic [3:0] jpat();
    return {kpd_bus.J1, kpd_bus.J2, kpd_bus.J3, kpd_bus.J4};
  endfunction

  logic [3:0] col_pat [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  initial begin
    // Reset state
    repeat (3) @(negedge slow_clk);
    check("rst_cols", {28'd0, jpat()}, 32'h7);
    check("rst_pressed", {31'd0, kpd_bus.pressed}, 32'd0);
    check("rst_outnum", {28'd0, kpd_bus.outnum}, 32'hF);

    // Idle scan: one column low per SETTLE cycles, J1 first
    rst = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      check("scan_cols", {28'd0, jpat()}, {28'd0, col_pat[k / SETTLE]});
      if (k % SETTLE == 0) begin
        check("scan_pressed", {31'd0, kpd_bus.pressed}, 32'd0);
        check("scan_outnum", {28'd0, kpd_bus.outnum}, 32'hF);
      end
      @(negedge slow_clk);
    end
    check("wrap_cols", {28'd0, jpat()}, 32'h7);

    // Key 5 pressed and held
    keys = 16'h0020;
    wait_pressed(1'b1);
    check("k5_pressed", {31'd0, kpd_bus.pressed}, 32'd1);
    check("k5_outnum", {28'd0, kpd_bus.outnum}, 32'h5);
    for (int i = 0; i < 4; i++) begin
      repeat (8) @(negedge slow_clk);
      check("k5_hold_p", {31'd0, kpd_bus.pressed}, 32'd1);
      check("k5_hold_n", {28'd0, kpd_bus.outnum}, 32'h5);
    end

    // Release: pressed drops, outnum keeps the last key
    keys = 16'h0000;
    wait_pressed(1'b0);
    check("rel5_pressed", {31'd0, kpd_bus.pressed}, 32'd0);
    check("rel5_outnum", {28'd0, kpd_bus.outnum}, 32'h5);
    repeat (FRAME) @(negedge slow_clk);
    check("rel5_hold", {28'd0, kpd_bus.outnum}, 32'h5);

    // 3 and 7 together: column J1 (key 7) wins over J3 (key 3)
    keys = 16'h0104;
    wait_pressed(1'b1);
    repeat (FRAME) @(negedge slow_clk);
    check("k37_pressed", {31'd0, kpd_bus.pressed}, 32'd1);
    check("k37_outnum", {28'd0, kpd_bus.outnum}, 32'h7);
    keys = 16'h0000;
    wait_pressed(1'b0);
    check("rel37_pressed", {31'd0, kpd_bus.pressed}, 32'd0);

    // Same row, two columns: 4 (J1) beats 6 (J3)
    keys = 16'h0050;
    wait_pressed(1'b1);
    repeat (FRAME) @(negedge slow_clk);
    check("k46_outnum", {28'd0, kpd_bus.outnum}, 32'h4);
    keys = 16'h0000;
    wait_pressed(1'b0);

    // Same column, two rows: 2 (J7) beats F (J10)
    keys = 16'h2002;
    wait_pressed(1'b1);
    repeat (FRAME) @(negedge slow_clk);
    check("k2f_outnum", {28'd0, kpd_bus.outnum}, 32'h2);
    keys = 16'h0000;
    wait_pressed(1'b0);

    // Key D: row J10, column J4
    keys = 16'h8000;
    wait_pressed(1'b1);
    check("kD_pressed", {31'd0, kpd_bus.pressed}, 32'd1);
    check("kD_outnum", {28'd0, kpd_bus.outnum}, 32'hD);
    keys = 16'h0000;
    wait_pressed(1'b0);

    // Key 0: row J10, column J1
    keys = 16'h1000;
    wait_pressed(1'b1);
    check("k0_pressed", {31'd0, kpd_bus.pressed}, 32'd1);
    check("k0_outnum", {28'd0, kpd_bus.outnum}, 32'h0);
    keys = 16'h0000;
    wait_pressed(1'b0);

    // Key 9 held, reset mid-frame
    keys = 16'h0400;
    wait_pressed(1'b1);
    check("k9_outnum", {28'd0, kpd_bus.outnum}, 32'h9);
    repeat (5) @(negedge slow_clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_pressed", {31'd0, kpd_bus.pressed}, 32'd0);
    check("mid_rst_outnum", {28'd0, kpd_bus.outnum}, 32'hF);
    check("mid_rst_cols", {28'd0, jpat()}, 32'h7);
    repeat (2) @(negedge slow_clk);
    rst = 1'b1;
    check("post_rst_cols", {28'd0, jpat()}, 32'h7);
    repeat (FRAME) @(negedge slow_clk);
    check("post_rst_early", {31'd0, kpd_bus.pressed}, 32'd0);
    @(negedge slow_clk);
    check("post_rst_pressed", {31'd0, kpd_bus.pressed}, 32'd1);
    check("post_rst_outnum", {28'd0, kpd_bus.outnum}, 32'h9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
